// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM state encoding plus the ACK and R/W bit values
// that the master and the bus slave both rely on.
package i2c_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 4'd0,
        ST_START       = 4'd1,
        ST_SEND_ADDR   = 4'd2,
        ST_ADDR_ACK    = 4'd3,
        ST_SEND_REG    = 4'd4,
        ST_REG_ACK     = 4'd5,
        ST_SEND_DATA   = 4'd6,
        ST_DATA_ACK    = 4'd7,
        ST_READ_DATA   = 4'd8,
        ST_MASTER_NACK = 4'd9,
        ST_STOP        = 4'd10
    } i2c_state_t;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-bit tick generator: one-cycle tick every CLK_DIV clocks, restartable so a
// new transaction always begins on a full quarter.
module i2c_clk_div #(
    parameter int CLK_DIV = 16
) (
    input  logic Clock_In,
    input  logic Reset_In,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            cnt_reg <= '0;
        end else if (restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller issuing register writes and single-byte reads.
// Every bus action happens on a quarter tick; each bit spans four quarters.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic       M_Start_In,
    input  logic [6:0] M_Slave_Address_In,
    input  logic       M_Read_Writeb_In,
    input  logic [7:0] M_Reg_Address_In,
    input  logic [7:0] M_Data_In,
    output logic [7:0] M_Data_Out,
    output logic       M_Busy_Out,
    output logic       M_Done_Out,
    output logic       M_Ack_Error_Out,
    output tri         I2C_SCL,
    inout  tri         I2C_SDA
);

    i2c_state_t state_reg, state_next;
    logic [1:0] phase_reg, phase_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] addr_rw_reg, addr_rw_next;
    logic [7:0] reg_addr_reg, reg_addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic [7:0] rx_reg, rx_next;
    logic [7:0] data_out_reg, data_out_next;
    logic       scl_oe_reg, scl_oe_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       ack_err_reg, ack_err_next;
    logic       nack_reg, nack_next;
    logic       sample_reg, sample_next;
    logic       restart, tick, sda_in, is_send, last_bit;
    logic [7:0] tx_byte;

    i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .Clock_In (Clock_In),
        .Reset_In (Reset_In),
        .restart  (restart),
        .tick     (tick)
    );

    // Open-drain pins: only ever pulled low, released otherwise.
    assign I2C_SCL = scl_oe_reg ? 1'b0 : 1'bz;
    assign I2C_SDA = sda_oe_reg ? 1'b0 : 1'bz;
    assign sda_in  = I2C_SDA;

    assign M_Data_Out      = data_out_reg;
    assign M_Busy_Out      = busy_reg;
    assign M_Done_Out      = done_reg;
    assign M_Ack_Error_Out = ack_err_reg;

    assign is_send  = (state_reg == ST_SEND_ADDR) || (state_reg == ST_SEND_REG) ||
                      (state_reg == ST_SEND_DATA);
    assign last_bit = (bit_cnt_reg == 3'd0);

    always_comb begin
        case (state_reg)
            ST_SEND_ADDR: tx_byte = addr_rw_reg;
            ST_SEND_REG:  tx_byte = reg_addr_reg;
            default:      tx_byte = wdata_reg;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        bit_cnt_next  = bit_cnt_reg;
        addr_rw_next  = addr_rw_reg;
        reg_addr_next = reg_addr_reg;
        wdata_next    = wdata_reg;
        rx_next       = rx_reg;
        data_out_next = data_out_reg;
        scl_oe_next   = scl_oe_reg;
        sda_oe_next   = sda_oe_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        ack_err_next  = ack_err_reg;
        nack_next     = nack_reg;
        sample_next   = sample_reg;
        restart       = 1'b0;

        if (state_reg == ST_IDLE) begin
            scl_oe_next = 1'b0;
            sda_oe_next = 1'b0;
            if (M_Start_In) begin
                addr_rw_next  = {M_Slave_Address_In, M_Read_Writeb_In};
                reg_addr_next = M_Reg_Address_In;
                wdata_next    = M_Data_In;
                busy_next     = 1'b1;
                ack_err_next  = 1'b0;
                nack_next     = 1'b0;
                phase_next    = 2'd0;
                restart       = 1'b1;
                state_next    = ST_START;
            end
        end else if (tick) begin
            phase_next = phase_reg + 2'd1;
            case (state_reg)
                ST_START: begin
                    case (phase_reg)
                        2'd0: begin
                            scl_oe_next = 1'b0;
                            sda_oe_next = 1'b0;
                        end
                        2'd1: sda_oe_next = 1'b1;
                        default: begin
                            scl_oe_next  = 1'b1;
                            phase_next   = 2'd0;
                            bit_cnt_next = 3'd7;
                            state_next   = ST_SEND_ADDR;
                        end
                    endcase
                end
                ST_STOP: begin
                    case (phase_reg)
                        2'd0: sda_oe_next = 1'b1;
                        2'd1: scl_oe_next = 1'b0;
                        2'd2: sda_oe_next = 1'b1;
                        default: begin
                            sda_oe_next  = 1'b0;
                            busy_next    = 1'b0;
                            done_next    = 1'b1;
                            ack_err_next = nack_reg;
                            state_next   = ST_IDLE;
                        end
                    endcase
                end
                default: begin
                    case (phase_reg)
                        2'd0: begin
                            scl_oe_next = 1'b1;
                            sda_oe_next = is_send & ~tx_byte[bit_cnt_reg];
                        end
                        2'd1: scl_oe_next = 1'b0;
                        2'd2: begin
                            sample_next = sda_in;
                            if (state_reg == ST_READ_DATA) begin
                                rx_next = {rx_reg[6:0], sda_in};
                            end
                        end
                        default: begin
                            scl_oe_next = 1'b1;
                            // Data states count 7->0 and wrap back to 7 for the next byte.
                            if (is_send || state_reg == ST_READ_DATA) begin
                                bit_cnt_next = bit_cnt_reg - 3'd1;
                            end else begin
                                bit_cnt_next = 3'd7;
                            end
                            case (state_reg)
                                ST_SEND_ADDR: if (last_bit) state_next = ST_ADDR_ACK;
                                ST_SEND_REG:  if (last_bit) state_next = ST_REG_ACK;
                                ST_SEND_DATA: if (last_bit) state_next = ST_DATA_ACK;
                                ST_READ_DATA: begin
                                    if (last_bit) begin
                                        data_out_next = rx_reg;
                                        state_next    = ST_MASTER_NACK;
                                    end
                                end
                                ST_ADDR_ACK: begin
                                    if (sample_reg == NACK_BIT) begin
                                        nack_next  = 1'b1;
                                        state_next = ST_STOP;
                                    end else if (addr_rw_reg[0] == RW_READ) begin
                                        state_next = ST_READ_DATA;
                                    end else begin
                                        state_next = ST_SEND_REG;
                                    end
                                end
                                ST_REG_ACK: begin
                                    if (sample_reg == NACK_BIT) begin
                                        nack_next  = 1'b1;
                                        state_next = ST_STOP;
                                    end else begin
                                        state_next = ST_SEND_DATA;
                                    end
                                end
                                ST_DATA_ACK: begin
                                    if (sample_reg == NACK_BIT) begin
                                        nack_next = 1'b1;
                                    end
                                    state_next = ST_STOP;
                                end
                                default: state_next = ST_STOP;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= 2'd0;
            bit_cnt_reg  <= 3'd0;
            addr_rw_reg  <= 8'd0;
            reg_addr_reg <= 8'd0;
            wdata_reg    <= 8'd0;
            rx_reg       <= 8'd0;
            data_out_reg <= 8'd0;
            scl_oe_reg   <= 1'b0;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ack_err_reg  <= 1'b0;
            nack_reg     <= 1'b0;
            sample_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            bit_cnt_reg  <= bit_cnt_next;
            addr_rw_reg  <= addr_rw_next;
            reg_addr_reg <= reg_addr_next;
            wdata_reg    <= wdata_next;
            rx_reg       <= rx_next;
            data_out_reg <= data_out_next;
            scl_oe_reg   <= scl_oe_next;
            sda_oe_reg   <= sda_oe_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            ack_err_reg  <= ack_err_next;
            nack_reg     <= nack_next;
            sample_reg   <= sample_next;
        end
    end

endmodule
